// File: rtl/dac_axi_arbiter_if.sv
// AXI4-Lite write channel (AW, W, B) between the DAC sample arbiter and the DAC slave.
interface dac_axi_arbiter_if;
    logic        AWVALID;
    logic [31:0] AWADDR;
    logic        AWREADY;
    logic        WVALID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WREADY;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
        input  AWREADY, WREADY, BVALID
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
        output AWREADY, WREADY, BVALID
    );
endinterface

// File: rtl/dac_axi_arbiter.sv
// Round-robin arbiter: one AXI4-Lite write per grant. REQ->DONE is 4 cycles plus slave delays.
// Holds AWVALID/WVALID until each ready is seen; a watchdog aborts after TIMEOUT cycles without B.
module dac_axi_arbiter #(
    parameter int          NREQ      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          TIMEOUT   = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [12*NREQ-1:0]   SAMPLE,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      DONE,
    output logic                 ERR,
    input  logic                 ERR_CLR,
    output logic                 BUSY,
    dac_axi_arbiter_if.master    axi
);
    localparam int         PW       = $clog2(NREQ);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADDR   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   own_q;
    logic [NREQ-1:0] gnt_q;
    logic [11:0]     smp_q;
    logic            aw_vld_q;
    logic            w_vld_q;
    logic [15:0]     cnt;
    logic            err_q;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   cand;

    // First requester after the last winner, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!win_found && REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    logic aw_hs;
    logic w_hs;
    logic addr_fin;
    logic timeout;

    assign aw_hs    = aw_vld_q & axi.AWREADY;
    assign w_hs     = w_vld_q & axi.WREADY;
    assign addr_fin = (!aw_vld_q || axi.AWREADY) && (!w_vld_q || axi.WREADY);
    // A handshake that finishes the phase in the last allowed cycle takes precedence over the abort.
    assign timeout  = (cnt >= CNT_LAST) &&
                      (((state == S_ADDR) && !addr_fin) || ((state == S_RESP) && !axi.BVALID));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            ptr      <= PW'(NREQ - 1);
            own_q    <= '0;
            gnt_q    <= '0;
            smp_q    <= '0;
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
            cnt      <= '0;
            err_q    <= 1'b0;
        end else begin
            if (timeout) begin
                err_q <= 1'b1;
            end else if (ERR_CLR) begin
                err_q <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                        own_q    <= win_idx;
                        smp_q    <= SAMPLE[12*int'(win_idx) +: 12];
                        aw_vld_q <= 1'b1;
                        w_vld_q  <= 1'b1;
                        cnt      <= '0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    cnt <= cnt + 16'd1;
                    if (aw_hs) aw_vld_q <= 1'b0;
                    if (w_hs)  w_vld_q  <= 1'b0;
                    if (timeout) begin
                        aw_vld_q <= 1'b0;
                        w_vld_q  <= 1'b0;
                        state    <= S_FIN;
                    end else if (addr_fin) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    cnt <= cnt + 16'd1;
                    if (axi.BVALID || timeout) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    gnt_q <= '0;
                    ptr   <= own_q;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign GNT         = gnt_q;
    assign DONE        = (state == S_FIN) ? gnt_q : '0;
    assign BUSY        = (state != S_IDLE);
    assign ERR         = err_q;
    assign axi.AWVALID = aw_vld_q;
    assign axi.AWADDR  = BASE_ADDR;
    assign axi.WVALID  = w_vld_q;
    assign axi.WDATA   = {20'b0, smp_q};
    assign axi.WSTRB   = 4'hF;
    assign axi.BREADY  = (state == S_RESP);
endmodule

// File: tb/tb_dac_axi_arbiter.sv
// Bench for dac_axi_arbiter: vector table, corner sequences and randomized traffic vs. a reference model.
module tb_dac_axi_arbiter;
    localparam int          NREQ = 4;
    localparam logic [31:0] BASE = 32'h4000_0010;
    localparam int          TO   = 16;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NREQ-1:0]   REQ;
    logic [12*NREQ-1:0] SAMPLE;
    logic [NREQ-1:0]   GNT;
    logic [NREQ-1:0]   DONE;
    logic              ERR;
    logic              ERR_CLR;
    logic              BUSY;

    dac_axi_arbiter_if axi ();

    dac_axi_arbiter #(.NREQ(NREQ), .BASE_ADDR(BASE), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .SAMPLE(SAMPLE), .GNT(GNT), .DONE(DONE),
        .ERR(ERR), .ERR_CLR(ERR_CLR), .BUSY(BUSY), .axi(axi)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Slave model: each ready/valid asserts once the transaction is at least cfg_* cycles old.
    int cfg_aw = 0, cfg_w = 0, cfg_b = 0;
    int ts = -1;
    int aw_hs = 0, w_hs = 0, b_hs = 0;

    always @(negedge CLK) begin
        if (!BUSY) ts = -1;
        else       ts = ts + 1;
        axi.AWREADY = axi.AWVALID && (ts >= cfg_aw);
        axi.WREADY  = axi.WVALID  && (ts >= cfg_w);
        axi.BVALID  = axi.BREADY  && (cfg_b >= 0) && (ts >= cfg_b);
        if (axi.AWVALID && axi.AWREADY) aw_hs++;
        if (axi.WVALID  && axi.WREADY)  w_hs++;
        if (axi.BVALID  && axi.BREADY)  b_hs++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference timing from the protocol rules, counted from the first cycle AWVALID is high.
    task automatic model(input int aw, input int w, input int b,
                         output bit ok, output int done_t, output int awc, output int wc, output int brc);
        int ad, bh;
        ad     = (aw > w) ? aw : w;
        bh     = (b > ad + 1) ? b : ad + 1;
        ok     = (b >= 0) && (bh <= TO - 1);
        done_t = ok ? bh + 1 : TO;
        awc    = aw + 1;
        wc     = w + 1;
        brc    = ok ? bh - ad : TO - 1 - ad;
    endtask

    task automatic run_txn(input string nm, input logic [NREQ-1:0] req_set, input int aw, input int w,
                           input int b, input bit clr, input bit drop, input int exp_w, input bit exp_err);
        bit ok;
        int e_done, e_awc, e_wc, e_brc;
        int t, awc, wc, brc, a0, w0, b0;
        logic [31:0] wd, aa;
        logic [3:0]  ws, g0, dv;
        logic [11:0] es;
        model(aw, w, b, ok, e_done, e_awc, e_wc, e_brc);
        es = SAMPLE[12*exp_w +: 12];
        cfg_aw = aw; cfg_w = w; cfg_b = b;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs;
        REQ = req_set;
        ERR_CLR = clr;
        t = -1; awc = 0; wc = 0; brc = 0; dv = '0;
        wd = '0; aa = '0; ws = '0; g0 = '0;
        for (int c = 0; c < 200; c++) begin
            @(posedge CLK); #1;
            ERR_CLR = 1'b0;
            if (t < 0 && axi.AWVALID) t = 0;
            else if (t >= 0) t++;
            if (t == 0) begin
                wd = axi.WDATA; aa = axi.AWADDR; ws = axi.WSTRB; g0 = GNT;
                if (drop) REQ = REQ & ~GNT;
            end
            if (axi.AWVALID) awc++;
            if (axi.WVALID)  wc++;
            if (axi.BREADY)  brc++;
            if (DONE != '0) begin
                dv = DONE;
                break;
            end
        end
        chk({nm, " done"},     32'(dv), 32'(4'b1 << exp_w));
        chk({nm, " gnt"},      32'(g0), 32'(4'b1 << exp_w));
        chk({nm, " wdata"},    wd, {20'b0, es});
        chk({nm, " awaddr"},   aa, BASE);
        chk({nm, " wstrb"},    32'(ws), 32'hF);
        chk({nm, " err"},      32'(ERR), 32'(exp_err));
        chk({nm, " done_lat"}, t, e_done);
        chk({nm, " awv_cyc"},  awc, e_awc);
        chk({nm, " wv_cyc"},   wc, e_wc);
        chk({nm, " brdy_cyc"}, brc, e_brc);
        chk({nm, " aw_hs"},    aw_hs - a0, 1);
        chk({nm, " w_hs"},     w_hs - w0, 1);
        chk({nm, " b_hs"},     b_hs - b0, ok ? 1 : 0);
        @(posedge CLK); #1;
        chk({nm, " busy_idle"}, 32'(BUSY), 0);
        chk({nm, " done_1cyc"}, 32'(DONE), 0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [47:0] smp;
        int          aw;
        int          w;
        int          b;
        bit          clr;
        bit          drop;
        int          exp_w;
        bit          exp_err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int ptr_m, wsel, aw, wv, b, idx;
        bit err_m, ok, clr, drop, seen;
        int d0, d1, d2, d3;
        logic [3:0]  pend, dacc;
        logic [47:0] smp_m;

        tbl[0]  = '{4'b1111, 48'h103_102_101_100, 1, 2, 6,  0, 0, 0, 0};
        tbl[1]  = '{4'b1111, 48'h103_102_101_100, 1, 2, 6,  0, 0, 1, 0};
        tbl[2]  = '{4'b1111, 48'h103_102_101_100, 1, 2, 6,  0, 0, 2, 0};
        tbl[3]  = '{4'b1111, 48'h103_102_101_100, 1, 2, 6,  0, 0, 3, 0};
        tbl[4]  = '{4'b1111, 48'h103_102_101_100, 1, 2, 6,  0, 0, 0, 0};
        tbl[5]  = '{4'b0001, 48'h000_000_000_ABC, 1, 2, 14, 0, 0, 0, 0};
        tbl[6]  = '{4'b0110, 48'h000_555_AAA_000, 0, 0, 0,  0, 0, 1, 0};
        tbl[7]  = '{4'b0110, 48'h000_555_AAA_000, 5, 2, 8,  0, 0, 2, 0};
        tbl[8]  = '{4'b1000, 48'h7FF_000_000_000, 1, 2, -1, 0, 0, 3, 1};
        tbl[9]  = '{4'b0001, 48'h000_000_000_5A5, 1, 2, 6,  0, 1, 0, 1};
        tbl[10] = '{4'b0010, 48'h000_000_123_000, 1, 2, 15, 1, 0, 1, 0};
        tbl[11] = '{4'b0100, 48'h000_FFF_000_000, 1, 2, 16, 0, 0, 2, 1};
        tbl[12] = '{4'b1001, 48'h321_000_000_001, 1, 2, -1, 1, 0, 3, 1};

        RST = 1'b0; REQ = '0; SAMPLE = '0; ERR_CLR = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst awvalid", 32'(axi.AWVALID), 0);
        chk("rst wvalid",  32'(axi.WVALID), 0);
        chk("rst bready",  32'(axi.BREADY), 0);
        chk("rst gnt",     32'(GNT), 0);
        chk("rst done",    32'(DONE), 0);
        chk("rst err",     32'(ERR), 0);
        chk("rst busy",    32'(BUSY), 0);
        chk("rst wdata",   axi.WDATA, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        foreach (tbl[i]) begin
            SAMPLE = tbl[i].smp;
            run_txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].aw, tbl[i].w, tbl[i].b,
                    tbl[i].clr, tbl[i].drop, tbl[i].exp_w, tbl[i].exp_err);
        end

        // Sticky error survives idle cycles and clears on one ERR_CLR pulse.
        REQ = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("err sticky", 32'(ERR), 1);
        ERR_CLR = 1'b1;
        @(posedge CLK); #1;
        ERR_CLR = 1'b0;
        chk("err cleared", 32'(ERR), 0);

        // Asynchronous reset while waiting for the write response.
        SAMPLE = 48'h000_9C4_000_00F;
        cfg_aw = 1; cfg_w = 2; cfg_b = -1;
        REQ = 4'b0001;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(posedge CLK); #1;
            seen = axi.BREADY;
        end
        chk("rst_mid reached_resp", 32'(seen), 1);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("rst_mid awvalid", 32'(axi.AWVALID), 0);
        chk("rst_mid wvalid",  32'(axi.WVALID), 0);
        chk("rst_mid bready",  32'(axi.BREADY), 0);
        chk("rst_mid gnt",     32'(GNT), 0);
        chk("rst_mid busy",    32'(BUSY), 0);
        chk("rst_mid wdata",   axi.WDATA, 0);
        REQ = '0;
        dacc = DONE;
        repeat (2) begin
            @(posedge CLK); #1;
            dacc = dacc | DONE;
        end
        chk("rst_mid no_done", 32'(dacc), 0);
        RST = 1'b1;
        run_txn("rst_after", 4'b0100, 1, 2, 14, 0, 0, 2, 0);

        // Randomized traffic against the round-robin/timeout reference.
        ptr_m = 2; err_m = 1'b0; pend = '0; smp_m = '0;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    smp_m[12*i +: 12] = 12'($urandom);
                end
            end
            if (pend == '0) begin
                idx = int'($urandom_range(0, NREQ - 1));
                pend[idx] = 1'b1;
                smp_m[12*idx +: 12] = 12'($urandom);
            end
            SAMPLE = smp_m;
            wsel = -1;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (ptr_m + k) % NREQ;
                if (wsel < 0 && pend[idx]) wsel = idx;
            end
            aw   = int'($urandom_range(0, 4));
            wv   = int'($urandom_range(0, 4));
            b    = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 18));
            clr  = ($urandom_range(0, 3) == 0);
            drop = ($urandom_range(0, 4) == 0);
            model(aw, wv, b, ok, d0, d1, d2, d3);
            if (clr) err_m = 1'b0;
            if (!ok) err_m = 1'b1;
            run_txn($sformatf("rnd%0d", it), pend, aw, wv, b, clr, drop, wsel, err_m);
            pend[wsel] = 1'b0;
            ptr_m = wsel;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dac_axi_arbiter.md
Name: dac_axi_arbiter

Overview:
- AXI4-Lite write master that shares one DAC_interface_AXI write channel among NREQ sample requesters.
- Arbitration is round-robin. For each grant the block issues one AXI write (AW, W and B channels) carrying the winner's 12-bit sample, then returns a per-requester completion pulse.
- Sits between DAC sample producers (waveform generators, CPU-side buffers) and the DAC slave.
- Includes a response watchdog so a hung slave cannot stall the requesters forever.

Parameters:
- NREQ, 4: number of requesters; 2..8.
- BASE_ADDR, 32'h0000_0000: value driven on AWADDR for every write.
- TIMEOUT, 64: cycles allowed from the first AW/W assertion to the B handshake before abort; 2..65535.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  REQ[i]=1 requests a write of SAMPLE slice i; held high until DONE[i].
- SAMPLE  in  12*NREQ  sample of requester i at bits [12i+11:12i]; sampled only at grant.
- GNT  out  NREQ  one-hot; high for requester i from grant until DONE[i].
- DONE  out  NREQ  one-cycle pulse on the owning requester's bit when its write ends (success or abort).
- ERR  out  1  sticky: a write was aborted on timeout.
- ERR_CLR  in  1  synchronous clear of ERR.
- BUSY  out  1  high in any state other than IDLE.
- AWVALID  out  1  AXI write-address valid.
- AWADDR  out  32  AXI write address; always BASE_ADDR.
- AWREADY  in  1  AXI write-address ready.
- WVALID  out  1  AXI write-data valid.
- WDATA  out  32  {20'b0, latched sample}.
- WSTRB  out  4  constant 4'b1111.
- WREADY  in  1  AXI write-data ready.
- BVALID  in  1  AXI write-response valid.
- BREADY  out  1  AXI write-response ready.

Behaviour:
- Reset (RST=0, asynchronous) clears all outputs and state:
  - AWVALID, WVALID, BREADY, GNT, DONE, ERR, BUSY = 0; WDATA = 0.
  - FSM = IDLE; round-robin pointer PTR = NREQ-1, so requester 0 has top priority first.
  - Timeout counter = 0.
- Reset mid-transaction drops all valids immediately. No DONE pulse is issued.
- FSM states:
  - IDLE: if any REQ is high, select winner W = first index with REQ high searching PTR+1, PTR+2, ... modulo NREQ. Latch SAMPLE slice W into the WDATA register, set GNT[W], clear the counter, go to ADDR.
  - ADDR: AWVALID and WVALID both high. AW and W handshakes are tracked independently; a valid drops in the cycle after its own ready is sampled high. AWREADY and WREADY may arrive in the same or different cycles. When both handshakes are done, go to RESP.
  - RESP: BREADY=1. When BVALID=1, the handshake completes that cycle; go to FIN.
  - FIN: DONE[W] pulses for one cycle, GNT clears, PTR=W, go to IDLE. The next arbitration happens at the earliest in the following cycle, giving one idle cycle between transactions.
- AWVALID/WVALID are never withdrawn before their ready; WDATA and AWADDR are stable while the valids are high.
- Timeout counter:
  - Increments each cycle in ADDR and RESP.
  - When it reaches TIMEOUT-1 with no completing handshake in that cycle: drop AWVALID, WVALID and BREADY, set ERR, go to FIN (DONE still pulses, PTR still updates).
  - A handshake completing in the same cycle as the timeout wins, and ERR is not set.
- ERR_CLR: clears ERR unless a timeout sets it in the same cycle; set wins.
- REQ deasserting after grant is ignored: the latched write completes and DONE still pulses.
- Requests arriving during a transaction wait. Round-robin guarantees each active requester is served within NREQ transactions.
- Latency against the stock DAC slave, from REQ to DONE:
  - AWREADY arrives 1 cycle after AWVALID; WREADY 1 cycle after the AW handshake.
  - BVALID arrives about 12 cycles later.
  - Total about 16 cycles, well under the default TIMEOUT of 64.

Test Plan:
- Single request: REQ=4'b0001, SAMPLE[11:0]=12'hABC, slave model of the stock DAC → AWADDR=BASE_ADDR, WDATA=32'h0000_0ABC, WSTRB=4'hF, one DONE[0] pulse, ERR=0, BUSY back to 0.
- Round-robin fairness: REQ=4'b1111 held, samples 12'h100..12'h103 → grant order 0,1,2,3,0; WDATA values in order 0x100, 0x101, 0x102, 0x103.
- Handshake skew: WREADY asserted 3 cycles before AWREADY, then AWREADY 5 cycles late → WVALID drops after its handshake, AWVALID is held until AWREADY, exactly one write occurs, DONE pulses once.
- Timeout: slave never asserts BVALID, TIMEOUT=16 → BREADY drops 16 cycles after ADDR entry, ERR=1, DONE pulses. ERR stays 1 until an ERR_CLR pulse, then reads 0.
- Async reset mid-RESP: RST low for 2 cycles while BREADY=1 → all outputs 0 immediately, no DONE. After release with REQ=4'b0100, requester 2 is granted and completes normally.
- Late BVALID: BVALID arrives in the same cycle the counter hits TIMEOUT-1 → normal completion, ERR remains 0.
